inst_rom_arbiter: RTL and testbench

//  Shares the single-port instruction ROM between the fetch stage (IF) and the

---
 rtl/inst_rom_arbiter.sv | 110 +++++++++++
 tb/tb_inst_rom_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_arbiter.sv
// Shares the single-port instruction ROM between fetch (IF) and the load port (LS).
// Optional performance counters are enabled by defining ARB_PERF_CNT_EN.
module inst_rom_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 32,
   parameter int PC_W         = 32,
   parameter int INST_W       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              if_req,
   input  logic [PC_W-1:0]   if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [INST_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic [PC_W-1:0]   ls_addr,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [INST_W-1:0] ls_rdata,
   output logic              rom_ce,
   output logic [PC_W-1:0]   rom_pc,
   input  logic [INST_W-1:0] rom_inst
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  if_gnt_cnt,
   output logic [CNT_W-1:0]  ls_gnt_cnt,
   output logic [CNT_W-1:0]  conflict_cnt
`endif
);

   localparam logic CHIP_ENABLE  = 1'b1;
   localparam logic CHIP_DISABLE = 1'b0;
   localparam int   SW           = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   logic [SW-1:0]     starveCnt_q, starveCnt_d;
   logic              ifRvalid_q, lsRvalid_q;
   logic [INST_W-1:0] ifRdata_q, lsRdata_q;
   logic              forceIf;
   logic              ifGnt, lsGnt;

   // Grants are gated by rst_n so they drop the instant reset asserts.
   always_comb begin
      forceIf     = (starveCnt_q == LIMIT);
      lsGnt       = rst_n && ls_req && !forceIf;
      ifGnt       = rst_n && !lsGnt && if_req && !flush;
      starveCnt_d = starveCnt_q;
      if (ifGnt || !if_req) begin
         starveCnt_d = '0;
      end else if (lsGnt && (starveCnt_q < LIMIT)) begin
         starveCnt_d = starveCnt_q + SW'(1);
      end
      rom_ce = CHIP_DISABLE;
      rom_pc = '0;
      if (lsGnt) begin
         rom_ce = CHIP_ENABLE;
         rom_pc = ls_addr;
      end else if (ifGnt) begin
         rom_ce = CHIP_ENABLE;
         rom_pc = if_addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starveCnt_q <= '0;
         ifRvalid_q  <= 1'b0;
         lsRvalid_q  <= 1'b0;
         ifRdata_q   <= '0;
         lsRdata_q   <= '0;
      end else begin
         starveCnt_q <= starveCnt_d;
         ifRvalid_q  <= ifGnt;
         lsRvalid_q  <= lsGnt;
         if (ifGnt) ifRdata_q <= rom_inst;
         if (lsGnt) lsRdata_q <= rom_inst;
      end
   end

   // A flush in the response cycle squashes the fetch that is still landing.
   assign if_gnt    = ifGnt;
   assign ls_gnt    = lsGnt;
   assign if_rvalid = ifRvalid_q && !flush;
   assign ls_rvalid = lsRvalid_q;
   assign if_rdata  = ifRdata_q;
   assign ls_rdata  = lsRdata_q;

`ifdef ARB_PERF_CNT_EN
   logic [CNT_W-1:0] ifGntCnt_q, lsGntCnt_q, conflictCnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifGntCnt_q    <= '0;
         lsGntCnt_q    <= '0;
         conflictCnt_q <= '0;
      end else begin
         if (ifGnt) ifGntCnt_q <= ifGntCnt_q + CNT_W'(1);
         if (lsGnt) lsGntCnt_q <= lsGntCnt_q + CNT_W'(1);
         if (if_req && ls_req) conflictCnt_q <= conflictCnt_q + CNT_W'(1);
      end
   end

   assign if_gnt_cnt   = ifGntCnt_q;
   assign ls_gnt_cnt   = lsGntCnt_q;
   assign conflict_cnt = conflictCnt_q;
`endif

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Self-checking bench for inst_rom_arbiter: cycle table plus hand sequences for
// flush, mid-transaction reset, idle and (with ARB_PERF_CNT_EN) the perf counters.
module tb_inst_rom_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        if_req, ls_req;
   logic [31:0] if_addr, ls_addr;
   logic        if_gnt, ls_gnt, if_rvalid, ls_rvalid, rom_ce;
   logic [31:0] if_rdata, ls_rdata, rom_pc, rom_inst;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] if_gnt_cnt, ls_gnt_cnt, conflict_cnt;
`endif

   int nCompared   = 0;
   int nMismatched = 0;

   inst_rom_arbiter #(.STARVE_LIMIT(4), .CNT_W(32), .PC_W(32), .INST_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .ls_req    (ls_req),
      .ls_addr   (ls_addr),
      .ls_gnt    (ls_gnt),
      .ls_rvalid (ls_rvalid),
      .ls_rdata  (ls_rdata),
      .rom_ce    (rom_ce),
      .rom_pc    (rom_pc),
      .rom_inst  (rom_inst)
`ifdef ARB_PERF_CNT_EN
      ,
      .if_gnt_cnt   (if_gnt_cnt),
      .ls_gnt_cnt   (ls_gnt_cnt),
      .conflict_cnt (conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   // ROM word i holds 0xC0DE0000 | i; the low two address bits are ignored.
   assign rom_inst = 32'hC0DE0000 | {16'h0000, rom_pc[17:2]};

   typedef struct {
      logic        ifReq;
      logic [31:0] ifAddr;
      logic        lsReq;
      logic [31:0] lsAddr;
      logic        flush;
      logic        eIfGnt;
      logic        eLsGnt;
      logic        eRomCe;
      logic [31:0] eRomPc;
      logic        eIfRv;
      logic [31:0] eIfData;
      logic        eLsRv;
      logic [31:0] eLsData;
   } vec_t;

   vec_t vecs[25];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                                input logic lsReq, input logic [31:0] lsAddr,
                                input logic fl);
      @(negedge clk);
      if_req  = ifReq;
      if_addr = ifAddr;
      ls_req  = lsReq;
      ls_addr = lsAddr;
      flush   = fl;
      #1;
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, " if_gnt"},    32'(if_gnt),    32'd0);
      checkOutput({tag, " ls_gnt"},    32'(ls_gnt),    32'd0);
      checkOutput({tag, " rom_ce"},    32'(rom_ce),    32'd0);
      checkOutput({tag, " rom_pc"},    rom_pc,         32'd0);
      checkOutput({tag, " if_rvalid"}, 32'(if_rvalid), 32'd0);
      checkOutput({tag, " ls_rvalid"}, 32'(ls_rvalid), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0;
      if_req = 1'b0; ls_req = 1'b0; if_addr = '0; ls_addr = '0;

      // ifReq ifAddr lsReq lsAddr flush | ifGnt lsGnt ce pc | ifRv ifData lsRv lsData
      vecs[0]  = '{1'b1, 32'h000, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h000, 1'b0, 32'h0,         1'b0, 32'h0};
      vecs[1]  = '{1'b1, 32'h004, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h004, 1'b1, 32'hC0DE0000, 1'b0, 32'h0};
      vecs[2]  = '{1'b1, 32'h008, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h008, 1'b1, 32'hC0DE0001, 1'b0, 32'h0};
      vecs[3]  = '{1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 32'hC0DE0002, 1'b0, 32'h0};
      vecs[4]  = '{1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 32'hC0DE0002, 1'b0, 32'h0};
      vecs[5]  = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'hC0DE0002, 1'b0, 32'h0};
      vecs[6]  = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'hC0DE0002, 1'b1, 32'hC0DE0080};
      vecs[7]  = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'hC0DE0002, 1'b1, 32'hC0DE0080};
      vecs[8]  = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'hC0DE0002, 1'b1, 32'hC0DE0080};
      vecs[9]  = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'hC0DE0002, 1'b1, 32'hC0DE0080};
      vecs[10] = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'hC0DE0040, 1'b0, 32'hC0DE0080};
      vecs[11] = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'hC0DE0040, 1'b1, 32'hC0DE0080};
      vecs[12] = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'hC0DE0040, 1'b1, 32'hC0DE0080};
      vecs[13] = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'hC0DE0040, 1'b1, 32'hC0DE0080};
      vecs[14] = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'hC0DE0040, 1'b1, 32'hC0DE0080};
      vecs[15] = '{1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 32'hC0DE0040, 1'b0, 32'hC0DE0080};
      vecs[16] = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'hC0DE0040, 1'b0, 32'hC0DE0080};
      vecs[17] = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'hC0DE0040, 1'b1, 32'hC0DE0080};
      vecs[18] = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'hC0DE0040, 1'b1, 32'hC0DE0080};
      vecs[19] = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'hC0DE0040, 1'b1, 32'hC0DE0080};
      vecs[20] = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 32'hC0DE0040, 1'b1, 32'hC0DE0080};
      vecs[21] = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'hC0DE0040, 1'b0, 32'hC0DE0080};
      vecs[22] = '{1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 32'hC0DE0040, 1'b0, 32'hC0DE0080};
      vecs[23] = '{1'b0, 32'h000, 1'b1, 32'h207, 1'b1, 1'b0, 1'b1, 1'b1, 32'h207, 1'b0, 32'hC0DE0040, 1'b0, 32'hC0DE0080};
      vecs[24] = '{1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 32'hC0DE0040, 1'b1, 32'hC0DE0081};

      // Power-on reset state
      repeat (2) @(negedge clk);
      #1;
      checkIdleOutputs("reset");
      checkOutput("reset if_rdata", if_rdata, 32'd0);
      checkOutput("reset ls_rdata", ls_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Cycle table: fetch stream, idle, starvation pattern, force+flush, LS under flush
      for (int i = 0; i < 25; i++) begin
         applyStimulus(vecs[i].ifReq, vecs[i].ifAddr, vecs[i].lsReq, vecs[i].lsAddr, vecs[i].flush);
         checkOutput($sformatf("vec%0d if_gnt", i),    32'(if_gnt),    32'(vecs[i].eIfGnt));
         checkOutput($sformatf("vec%0d ls_gnt", i),    32'(ls_gnt),    32'(vecs[i].eLsGnt));
         checkOutput($sformatf("vec%0d rom_ce", i),    32'(rom_ce),    32'(vecs[i].eRomCe));
         checkOutput($sformatf("vec%0d rom_pc", i),    rom_pc,         vecs[i].eRomPc);
         checkOutput($sformatf("vec%0d if_rvalid", i), 32'(if_rvalid), 32'(vecs[i].eIfRv));
         checkOutput($sformatf("vec%0d if_rdata", i),  if_rdata,       vecs[i].eIfData);
         checkOutput($sformatf("vec%0d ls_rvalid", i), 32'(ls_rvalid), 32'(vecs[i].eLsRv));
         checkOutput($sformatf("vec%0d ls_rdata", i),  ls_rdata,       vecs[i].eLsData);
      end

      // Flush kills a due IF response and blocks IF, LS proceeds
      applyStimulus(1'b1, 32'h010, 1'b0, 32'h000, 1'b0);
      checkOutput("flush N if_gnt", 32'(if_gnt), 32'd1);
      checkOutput("flush N rom_pc", rom_pc, 32'h010);
      applyStimulus(1'b1, 32'h014, 1'b1, 32'h300, 1'b1);
      checkOutput("flush N+1 if_rvalid", 32'(if_rvalid), 32'd0);
      checkOutput("flush N+1 if_gnt", 32'(if_gnt), 32'd0);
      checkOutput("flush N+1 ls_gnt", 32'(ls_gnt), 32'd1);
      checkOutput("flush N+1 rom_pc", rom_pc, 32'h300);
      applyStimulus(1'b0, 32'h000, 1'b0, 32'h000, 1'b0);
      checkOutput("flush N+2 ls_rvalid", 32'(ls_rvalid), 32'd1);
      checkOutput("flush N+2 ls_rdata", ls_rdata, 32'hC0DE00C0);
      checkOutput("flush N+2 if_rvalid", 32'(if_rvalid), 32'd0);

      // Reset right after an LS grant drops the in-flight response
      applyStimulus(1'b0, 32'h000, 1'b1, 32'h040, 1'b0);
      checkOutput("rst pre ls_gnt", 32'(ls_gnt), 32'd1);
      @(negedge clk);
      rst_n = 1'b0; if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h0; ls_addr = 32'h40;
      #1;
      checkIdleOutputs("rst mid");
      checkOutput("rst mid if_rdata", if_rdata, 32'd0);
      checkOutput("rst mid ls_rdata", ls_rdata, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checkOutput($sformatf("rst hold%0d ls_rvalid", i), 32'(ls_rvalid), 32'd0);
         checkOutput($sformatf("rst hold%0d ls_gnt", i), 32'(ls_gnt), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1; if_req = 1'b1; if_addr = 32'h0; ls_req = 1'b0; ls_addr = 32'h0;
      #1;
      checkOutput("post-rst if_gnt", 32'(if_gnt), 32'd1);
      checkOutput("post-rst rom_ce", 32'(rom_ce), 32'd1);
      checkOutput("post-rst rom_pc", rom_pc, 32'h0);
      applyStimulus(1'b0, 32'h000, 1'b0, 32'h000, 1'b0);
      checkOutput("post-rst if_rvalid", 32'(if_rvalid), 32'd1);
      checkOutput("post-rst if_rdata", if_rdata, 32'hC0DE0000);
      checkOutput("post-rst ls_rvalid", 32'(ls_rvalid), 32'd0);

      // Ten idle cycles
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 32'h000, 1'b0, 32'h000, 1'b0);
         checkIdleOutputs($sformatf("idle%0d", i));
      end

`ifdef ARB_PERF_CNT_EN
      // Counters over 8 cycles of contention from a fresh reset
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
      applyStimulus(1'b0, 32'h000, 1'b0, 32'h000, 1'b0);
      checkOutput("perf conflict_cnt", conflict_cnt, 32'd8);
      checkOutput("perf ls_gnt_cnt", ls_gnt_cnt, 32'd7);
      checkOutput("perf if_gnt_cnt", if_gnt_cnt, 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
